// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch front end.
package fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_STEP  = 4;
    // Entries carry a PC wide enough for any supported XLEN (up to 64).
    localparam int PC_MAX_W = 64;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [INSTR_W-1:0]  instr;
        logic                filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at grant time and filled later,
// oldest-first, as memory responses return; the head is handed to decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_alloc,
    input  logic [XLEN-1:0]    i_allocPc,
    input  logic               i_fill,
    input  logic [INSTR_W-1:0] i_fillInstr,
    input  logic               i_pop,
    output logic [CNT_W-1:0]   o_count,
    output logic [CNT_W-1:0]   o_unfilled,
    output logic               o_headValid,
    output logic [XLEN-1:0]    o_headPc,
    output logic [INSTR_W-1:0] o_headInstr
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_fillPtr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_pend;

    logic w_doAlloc;
    logic w_doFill;
    logic w_doPop;

    assign o_headValid = (r_count != '0) && r_mem[r_head].filled;
    assign o_headPc    = o_headValid ? r_mem[r_head].pc[XLEN-1:0] : '0;
    assign o_headInstr = o_headValid ? r_mem[r_head].instr : '0;
    assign o_count     = r_count;
    assign o_unfilled  = r_pend;

    // A fill can never target the slot being allocated: that would need every entry pending.
    assign w_doAlloc = i_alloc && !i_clear && (r_count != CNT_W'(DEPTH));
    assign w_doFill  = i_fill  && !i_clear && (r_pend != '0);
    assign w_doPop   = i_pop   && !i_clear && o_headValid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_fillPtr <= '0;
            r_count   <= '0;
            r_pend    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_fillPtr <= '0;
            r_count   <= '0;
            r_pend    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].filled <= 1'b0;
            end
        end else begin
            if (w_doAlloc) begin
                r_mem[r_tail].pc     <= PC_MAX_W'(i_allocPc);
                r_mem[r_tail].instr  <= '0;
                r_mem[r_tail].filled <= 1'b0;
                r_tail               <= r_tail + PTR_W'(1);
            end
            if (w_doFill) begin
                r_mem[r_fillPtr].instr  <= i_fillInstr;
                r_mem[r_fillPtr].filled <= 1'b1;
                r_fillPtr               <= r_fillPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_doAlloc) - CNT_W'(w_doPop);
            r_pend  <= r_pend  + CNT_W'(w_doAlloc) - CNT_W'(w_doFill);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Decoupled fetch stage: PC generator with request credit, drop accounting for
// responses to flushed requests, and an in-order buffer feeding decode.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_br_taken,
    input  logic [XLEN-1:0]    i_br_addr,
    output logic               o_imem_req,
    output logic [XLEN-1:0]    o_imem_addr,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_id_valid,
    output logic [XLEN-1:0]    o_id_pc,
    output logic [INSTR_W-1:0] o_id_instr,
    input  logic               i_id_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_dropCnt;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_unfilled;
    logic             w_credit;
    logic             w_grant;
    logic             w_dropResp;
    logic             w_fill;

    // Buffered entries plus responses still owed for flushed requests bound the outstanding work.
    assign w_credit    = (SUM_W'(w_count) + SUM_W'(r_dropCnt)) < SUM_W'(DEPTH);
    assign o_imem_req  = !rst && !i_br_taken && w_credit;
    assign o_imem_addr = r_pc;
    assign w_grant     = o_imem_req && i_imem_gnt;
    assign w_dropResp  = i_imem_rvalid && (r_dropCnt != '0);
    assign w_fill      = i_imem_rvalid && (r_dropCnt == '0) && !i_br_taken;

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (i_br_taken),
        .i_alloc     (w_grant),
        .i_allocPc   (r_pc),
        .i_fill      (w_fill),
        .i_fillInstr (i_imem_rdata),
        .i_pop       (i_id_ready),
        .o_count     (w_count),
        .o_unfilled  (w_unfilled),
        .o_headValid (o_id_valid),
        .o_headPc    (o_id_pc),
        .o_headInstr (o_id_instr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_br_taken) begin
            r_pc <= i_br_addr;
        end else if (w_grant) begin
            r_pc <= r_pc + XLEN'(PC_STEP);
        end
    end

    // On a flush every allocated-unfilled entry becomes an owed response; a response
    // landing in the flush cycle settles one of those debts immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dropCnt <= '0;
        end else if (i_br_taken) begin
            r_dropCnt <= r_dropCnt + w_unfilled - CNT_W'(i_imem_rvalid);
        end else if (w_dropResp) begin
            r_dropCnt <= r_dropCnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a latency-configurable in-order memory model,
// an expected-entry queue pushed on grant and popped on each decode handshake.
module tb_if_fetch_unit;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          filled;
   } expEnt_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } memReq_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        brTaken;
   logic [31:0] brAddr;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic        idValid;
   logic [31:0] idPc;
   logic [31:0] idInstr;
   logic        idReady;

   logic        wReq;
   logic [31:0] wAddr;
   logic        wRvalid;
   logic [31:0] wRdata;
   logic        wValid;
   logic [31:0] wPc;
   logic [31:0] wInstr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   expEnt_t     expQ [$];
   memReq_t     memQ [$];
   logic [31:0] modelPc;
   int          modelDrop;
   int          memLat;

   int          grantCnt;
   int          popCnt;
   int          firstValidCyc;
   int          relBase;
   bit          firstPopSeen;
   logic [31:0] firstPopPc;
   logic [31:0] popPcs [$];
   int          popCycs [$];

   bit          wPend;
   logic [31:0] wPendAddr;
   int          wPops;
   logic [31:0] wrapExp [3];

   always #5 clk = ~clk;

   if_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .i_br_taken    (brTaken),
      .i_br_addr     (brAddr),
      .o_imem_req    (imemReq),
      .o_imem_addr   (imemAddr),
      .i_imem_gnt    (imemGnt),
      .i_imem_rvalid (imemRvalid),
      .i_imem_rdata  (imemRdata),
      .o_id_valid    (idValid),
      .o_id_pc       (idPc),
      .o_id_instr    (idInstr),
      .i_id_ready    (idReady)
   );

   if_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
      .clk           (clk),
      .rst           (rst),
      .i_br_taken    (1'b0),
      .i_br_addr     (32'h0),
      .o_imem_req    (wReq),
      .o_imem_addr   (wAddr),
      .i_imem_gnt    (1'b1),
      .i_imem_rvalid (wRvalid),
      .i_imem_rdata  (wRdata),
      .o_id_valid    (wValid),
      .o_id_pc       (wPc),
      .o_id_instr    (wInstr),
      .i_id_ready    (1'b1)
   );

   function automatic logic [31:0] instrFor(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle from a negedge, checks outputs against the model, then advances the model to the next edge.
   task automatic applyStimulus(input logic br, input logic [31:0] ba, input logic gnt, input logic rdy);
      bit      expReq;
      bit      expValid;
      bit      doGrant;
      bit      placed;
      int      unf;
      memReq_t mr;
      expEnt_t ee;
      brTaken    = br;
      brAddr     = ba;
      imemGnt    = gnt;
      idReady    = rdy;
      imemRvalid = (memQ.size() > 0) && (memQ[0].due <= cyc);
      imemRdata  = imemRvalid ? instrFor(memQ[0].addr) : 32'h0;
      wRvalid    = wPend;
      wRdata     = instrFor(wPendAddr);
      #1;
      expReq = !br && ((expQ.size() + modelDrop) < DEPTH);
      checkOutput("imemReq", 64'(imemReq), 64'(expReq));
      if (imemReq) checkOutput("imemAddr", 64'(imemAddr), 64'(modelPc));
      expValid = (expQ.size() > 0) && expQ[0].filled;
      checkOutput("idValid", 64'(idValid), 64'(expValid));
      if (idValid && expValid) begin
         checkOutput("idPc", 64'(idPc), 64'(expQ[0].pc));
         checkOutput("idInstr", 64'(idInstr), 64'(expQ[0].instr));
      end
      if (idValid && firstValidCyc < 0) firstValidCyc = cyc - relBase;
      if (idValid && rdy && !br) begin
         popCnt++;
         popPcs.push_back(idPc);
         popCycs.push_back(cyc);
         if (!firstPopSeen) begin
            firstPopSeen = 1'b1;
            firstPopPc   = idPc;
         end
      end

      doGrant = imemReq && gnt;
      if (doGrant) begin
         mr.addr = imemAddr;
         mr.due  = cyc + memLat;
         memQ.push_back(mr);
         grantCnt++;
      end
      if (imemRvalid) void'(memQ.pop_front());

      if (br) begin
         unf = 0;
         foreach (expQ[i]) if (!expQ[i].filled) unf++;
         modelDrop = modelDrop + unf - (imemRvalid ? 1 : 0);
         expQ.delete();
         modelPc = ba;
      end else begin
         if (expValid && rdy) void'(expQ.pop_front());
         if (imemRvalid) begin
            if (modelDrop > 0) begin
               modelDrop--;
            end else begin
               placed = 1'b0;
               foreach (expQ[i]) begin
                  if (!placed && !expQ[i].filled) begin
                     expQ[i].filled = 1'b1;
                     placed = 1'b1;
                  end
               end
               if (!placed) checkOutput("spuriousResp", 64'(imemRvalid), 64'd0);
            end
         end
         if (doGrant) begin
            ee.pc     = modelPc;
            ee.instr  = instrFor(modelPc);
            ee.filled = 1'b0;
            expQ.push_back(ee);
            modelPc = modelPc + 32'd4;
         end
      end

      if (wValid && wPops < 3) begin
         checkOutput("wrapPc", 64'(wPc), 64'(wrapExp[wPops]));
         checkOutput("wrapInstr", 64'(wInstr), 64'(instrFor(wrapExp[wPops])));
         wPops++;
      end
      wPend     = wReq;
      wPendAddr = wAddr;

      @(negedge clk);
      cyc++;
   endtask

   task automatic drainAll();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (expQ.size() == 0 && memQ.size() == 0 && modelDrop == 0) done = 1'b1;
         else applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      end
      if (expQ.size() == 0 && memQ.size() == 0 && modelDrop == 0) done = 1'b1;
      checkOutput("drainTimeout", 64'(done), 64'd1);
   endtask

   task automatic clearStats();
      grantCnt     = 0;
      popCnt       = 0;
      firstPopSeen = 1'b0;
      firstPopPc   = 32'h0;
      popPcs.delete();
      popCycs.delete();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      wrapExp[0] = 32'hFFFF_FFF8;
      wrapExp[1] = 32'hFFFF_FFFC;
      wrapExp[2] = 32'h0000_0000;
      rst = 1'b1;
      brTaken = 1'b0; brAddr = 32'h0; imemGnt = 1'b0; imemRvalid = 1'b0;
      imemRdata = 32'h0; idReady = 1'b0; wRvalid = 1'b0; wRdata = 32'h0;
      modelPc = 32'h0; modelDrop = 0; memLat = 1; wPend = 1'b0; wPendAddr = 32'h0;
      wPops = 0; firstValidCyc = -1; relBase = 0;
      clearStats();
      $display("[TB] start");

      repeat (3) @(negedge clk);
      imemGnt = 1'b1; idReady = 1'b1;
      #1;
      checkOutput("rstReq", 64'(imemReq), 64'd0);
      checkOutput("rstValid", 64'(idValid), 64'd0);
      checkOutput("rstPc", 64'(idPc), 64'd0);
      checkOutput("rstInstr", 64'(idInstr), 64'd0);
      checkOutput("rstAddr", 64'(imemAddr), 64'h0);
      checkOutput("rstWrapAddr", 64'(wAddr), 64'hFFFF_FFF8);
      @(negedge clk);
      rst = 1'b0;
      relBase = cyc;

      // Reset stream with a one-cycle memory.
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("firstValidCyc", 64'(firstValidCyc), 64'd2);
      checkOutput("streamPc0", 64'(popPcs[0]), 64'h0);
      checkOutput("streamPc1", 64'(popPcs[1]), 64'h4);
      checkOutput("streamPc2", 64'(popPcs[2]), 64'h8);
      checkOutput("streamGap01", 64'(popCycs[1] - popCycs[0]), 64'd1);
      checkOutput("streamGap12", 64'(popCycs[2] - popCycs[1]), 64'd1);

      // Backpressure: decode stalls while memory keeps granting.
      drainAll();
      clearStats();
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("bpGrants", 64'(grantCnt), 64'd4);
      #1;
      checkOutput("bpReqLow", 64'(imemReq), 64'd0);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("bpPops", 64'(popCnt), 64'd4);
      if (popCnt == 4) begin
         checkOutput("bpNoGaps", 64'(popCycs[3] - popCycs[0]), 64'd3);
         checkOutput("bpOrder", 64'(popPcs[3] - popPcs[0]), 64'd12);
      end

      // Flush with three requests in flight on a three-cycle memory.
      drainAll();
      clearStats();
      memLat = 3;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1);
      checkOutput("dropAfterFlush", 64'(u_dut.r_dropCnt), 64'd2);
      firstPopSeen = 1'b0;
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("firstPcAfterFlush", 64'(firstPopPc), 64'h100);
      drainAll();
      checkOutput("dropZero", 64'(u_dut.r_dropCnt), 64'd0);

      // Flush coinciding with a response and a decode pop; redirect also exercises PC wrap.
      memLat = 1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("coincValid", 64'(idValid), 64'd1);
      applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
      checkOutput("coincEmpty", 64'(u_dut.u_queue.r_count), 64'd0);
      checkOutput("coincNoValid", 64'(idValid), 64'd0);
      clearStats();
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("wrapMainPc0", 64'(popPcs[0]), 64'hFFFF_FFF8);
      checkOutput("wrapMainPc2", 64'(popPcs[2]), 64'h0);

      // Grant stall: request must hold steady with nothing allocated.
      drainAll();
      clearStats();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      checkOutput("stallReq", 64'(imemReq), 64'd1);
      checkOutput("stallAddr", 64'(imemAddr), 64'(modelPc));
      checkOutput("stallCount", 64'(u_dut.u_queue.r_count), 64'd0);
      checkOutput("stallValid", 64'(idValid), 64'd0);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      drainAll();

      checkOutput("wrapPops", 64'(wPops), 64'd3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage. It replaces the single-cycle PC/ROM fetch with a decoupled front end. A PC generator issues requests to a latency-tolerant instruction memory through a request/grant/response handshake. Returned instructions are buffered with their PC in an in-order queue and handed to ID through a valid/ready handshake. A taken branch flushes all in-flight and buffered work.

## Interface
- XLEN, 32, PC and address width.
- RESET_PC, 0, PC after reset.
- DEPTH, 4, queue entries; power of 2, ≥2; also the limit on outstanding memory requests.

Ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- br_taken  in  1  redirect/flush strobe from EX.
- br_addr  in  XLEN  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (= pc_q).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  head entry holds an instruction.
- id_pc  out  XLEN  PC of head instruction.
- id_instr  out  32  head instruction.
- id_ready  in  1  ID accepts the head this cycle.

## Operation
- State:
  - pc_q: next fetch address.
  - Circular queue of DEPTH entries {pc, instr, filled}, with head, tail and count.
  - drop_cnt: number of responses still owed for flushed requests, range 0..DEPTH.
- Request: imem_req = !rst && !br_taken && (count + drop_cnt < DEPTH). imem_addr = pc_q.
- A request is held with a stable address until granted, unless br_taken retracts it.
- Grant (imem_req && imem_gnt):
  - Allocate the tail entry with pc = pc_q and filled = 0.
  - pc_q <= pc_q + 4, modulo 2^XLEN; wrap from all-ones−3 to 0 is legal.
- Response (imem_rvalid):
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Otherwise: write instr into the oldest unfilled entry and set filled.
- id_valid = head entry allocated && filled. id_pc and id_instr come from the head.
- Pop on id_valid && id_ready.
- Flush (br_taken):
  - pc_q <= br_addr.
  - Queue cleared: count = 0, all filled = 0.
  - drop_cnt <= (drop_cnt + number of allocated-unfilled entries) − (imem_rvalid ? 1 : 0).
  - A response arriving in the flush cycle is always discarded.
  - A pop in the flush cycle has no effect.
  - br_taken has priority over every other event.
- Same-cycle grant, fill and pop are all legal together; count changes by allocs − pops.
- imem_rvalid with no owed response is a protocol error. The bench flags it; RTL behaviour is undefined.

## Timing
- Reset, while rst is high:
  - pc_q = RESET_PC, queue empty, drop_cnt = 0.
  - imem_req = 0, id_valid = 0, id_pc = 0, id_instr = 0.
  - imem_addr = RESET_PC.
- Reset mid-operation discards everything. Responses for pre-reset requests are the memory's responsibility to cancel.
- Response timing: earliest response is the cycle after its grant.
- Latency: fill is registered, so id_valid rises the cycle after the corresponding imem_rvalid. Minimum grant-to-id_valid is 2 cycles.
- Throughput: with a 1-cycle memory and id_ready held high, one instruction per cycle is sustained for DEPTH ≥ 3.
- Full queue: imem_req drops the cycle count + drop_cnt reaches DEPTH and re-asserts the cycle after a pop or a drop.
- Redirect: the first request to br_addr is issued the cycle after br_taken, provided credit allows.

## Structure
- Package fetch_pkg holds:
  - fetch_entry_t {pc, instr, filled}.
  - INSTR_W = 32.
  - PC_STEP = 4.
- Sub-module fetch_queue: circular buffer with alloc/fill/pop/clear ports, count output, and a fill pointer tracking the oldest unfilled entry.
- The top level holds pc_q, drop_cnt, and the request and flush logic.

## Test plan
- **Reset stream.** Release reset with a 1-cycle memory, gnt = 1 and id_ready = 1.
  - id_valid first asserts at cycle 2.
  - Handshakes then deliver PCs 0x0, 0x4, 0x8 on consecutive cycles with matching instr.
- **Backpressure.** id_ready = 0 for 10 cycles, DEPTH = 4.
  - Exactly 4 grants, then imem_req = 0.
  - After id_ready = 1, order is preserved and there are no gaps or duplicates.
- **Flush with in-flight requests.** Memory latency 3, 3 requests outstanding, br_taken with br_addr = 0x100.
  - The 3 stale responses are discarded.
  - The first id_pc seen is 0x100.
  - drop_cnt returns to 0.
- **Flush with coincident events.** br_taken coincides with imem_rvalid and an ID pop.
  - The response is dropped, the pop is ignored, and the queue is empty next cycle.
- **PC wrap.** RESET_PC = 0xFFFFFFF8.
  - Delivered PCs are 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- **Grant stall.** imem_gnt = 0 for 5 cycles.
  - imem_req and imem_addr stay stable.
  - No allocation occurs and id_valid stays 0.
